// File: rtl/lsu_ctrl_if.sv
// Data-bus interface between the load/store unit (master) and the memory
// system (slave). One request phase (valid/ready), then one response beat
// (rvalid) carrying read data and an error flag for both reads and writes.
interface lsu_ctrl_if #(
  parameter int ISA_WIDTH = 32
);
  logic                 bus_valid;
  logic                 bus_ready;
  logic                 bus_we;
  logic [ISA_WIDTH-1:0] bus_addr;
  logic [ISA_WIDTH-1:0] bus_wdata;
  logic [3:0]           bus_wstrb;
  logic                 bus_rvalid;
  logic [ISA_WIDTH-1:0] bus_rdata;
  logic                 bus_err;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ready, bus_rvalid, bus_rdata, bus_err
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_ready, bus_rvalid, bus_rdata, bus_err
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit controller. Accepts one memory request at a time from the
// execute stage, runs a request/response transaction on the data bus, builds
// byte strobes and lane-replicated data for stores, and extends load data
// before returning it on mem_r. Illegal accesses fault without touching the
// bus; a cycle counter aborts accesses the bus never completes.
// The bus is a 32-bit word with four byte lanes.
module lsu_ctrl #(
  parameter int ISA_WIDTH = 32,
  parameter int TIMEOUT   = 255,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 mem_r_en,
  input  logic                 mem_w_en,
  input  logic [ISA_WIDTH-1:0] mem_addr,
  input  logic [ISA_WIDTH-1:0] mem_w,
  input  logic [1:0]           mem_size,
  input  logic                 mem_unsigned,
  lsu_ctrl_if.master           bus,
  output logic [ISA_WIDTH-1:0] mem_r,
  output logic                 done,
  output logic                 fault,
  output logic                 busy
);

  localparam int                 NB      = 4;
  localparam logic [1:0]         SZ_BYTE = 2'd0;
  localparam logic [1:0]         SZ_HALF = 2'd1;
  localparam logic [1:0]         SZ_WORD = 2'd2;
  localparam logic [1:0]         SZ_BAD  = 2'd3;
  localparam bit                 TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_WIDTH:0] TO_LIM  = (CNT_WIDTH+1)'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, RESP, FLT} state_t;

  state_t               state_reg, state_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic [ISA_WIDTH-1:0] addr_reg, addr_next;
  logic [ISA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [ISA_WIDTH-1:0] mem_r_reg, mem_r_next;
  logic [NB-1:0]        wstrb_reg, wstrb_next;
  logic [1:0]           size_reg, size_next;
  logic                 uns_reg, uns_next;
  logic                 we_reg, we_next;
  logic                 done_reg, done_next;
  logic                 fault_reg, fault_next;

  logic                 req_fire;
  logic                 req_illegal;
  logic                 timeout_hit;
  logic [ISA_WIDTH-1:0] st_wdata;
  logic [NB-1:0]        st_wstrb;
  logic [ISA_WIDTH-1:0] ld_data;
  logic [7:0]           rd_byte [NB];
  logic [15:0]          rd_half [NB/2];
  logic [7:0]           sel_byte;
  logic [15:0]          sel_half;

  // Acceptance needs at least one enable; a bare req_valid is ignored.
  assign req_fire = req_valid && (state_reg == IDLE) && (mem_r_en || mem_w_en);

  assign req_illegal = (mem_size == SZ_BAD)
                    || ((mem_size == SZ_HALF) && mem_addr[0])
                    || ((mem_size == SZ_WORD) && (mem_addr[1:0] != 2'b00))
                    || (mem_r_en && mem_w_en);

  // The counter value reached at the coming edge has hit the limit. Using >=
  // keeps a RESP phase entered exactly at the limit from running on forever.
  assign timeout_hit = TO_EN &&
    (({1'b0, cnt_reg} + {{CNT_WIDTH{1'b0}}, 1'b1}) >= TO_LIM);

  // Split read data into byte and halfword lanes for the load extractor.
  for (genvar gi = 0; gi < NB; gi++) begin : g_byte_lane
    assign rd_byte[gi] = bus.bus_rdata[8*gi +: 8];
  end
  for (genvar gi = 0; gi < NB/2; gi++) begin : g_half_lane
    assign rd_half[gi] = bus.bus_rdata[16*gi +: 16];
  end

  assign sel_byte = rd_byte[addr_reg[1:0]];
  assign sel_half = rd_half[addr_reg[1]];

  // Store lane replication and strobes, computed from the live request so
  // they can be latched on acceptance. Loads carry no strobes.
  always_comb begin
    st_wdata = mem_w;
    st_wstrb = 4'b1111;
    case (mem_size)
      SZ_BYTE: begin
        st_wdata = {NB{mem_w[7:0]}};
        st_wstrb = 4'b0001 << mem_addr[1:0];
      end
      SZ_HALF: begin
        st_wdata = {(NB/2){mem_w[15:0]}};
        st_wstrb = 4'b0011 << mem_addr[1:0];
      end
      default: ;
    endcase
    if (!mem_w_en) begin
      st_wstrb = '0;
    end
  end

  // Load extraction and sign/zero extension from the latched access shape.
  always_comb begin
    ld_data = bus.bus_rdata;
    case (size_reg)
      SZ_BYTE: ld_data = uns_reg ? {{(ISA_WIDTH-8){1'b0}}, sel_byte}
                                 : {{(ISA_WIDTH-8){sel_byte[7]}}, sel_byte};
      SZ_HALF: ld_data = uns_reg ? {{(ISA_WIDTH-16){1'b0}}, sel_half}
                                 : {{(ISA_WIDTH-16){sel_half[15]}}, sel_half};
      default: ;
    endcase
  end

  // Next-state logic: acceptance/latching, bus phases, timeout and completion.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    wstrb_next = wstrb_reg;
    size_next  = size_reg;
    uns_next   = uns_reg;
    we_next    = we_reg;
    mem_r_next = mem_r_reg;
    done_next  = 1'b0;
    fault_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (req_fire) begin
          addr_next  = mem_addr;
          wdata_next = st_wdata;
          wstrb_next = st_wstrb;
          size_next  = mem_size;
          uns_next   = mem_unsigned;
          we_next    = mem_w_en;
          cnt_next   = '0;
          state_next = req_illegal ? FLT : REQ;
        end
      end
      REQ: begin
        cnt_next = cnt_reg + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        if (bus.bus_ready) begin
          state_next = RESP;
        end else if (timeout_hit) begin
          state_next = IDLE;
          done_next  = 1'b1;
          fault_next = 1'b1;
        end
      end
      RESP: begin
        cnt_next = cnt_reg + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        if (bus.bus_rvalid) begin
          state_next = IDLE;
          done_next  = 1'b1;
          fault_next = bus.bus_err;
          if (!we_reg && !bus.bus_err) begin
            mem_r_next = ld_data;
          end
        end else if (timeout_hit) begin
          state_next = IDLE;
          done_next  = 1'b1;
          fault_next = 1'b1;
        end
      end
      FLT: begin
        state_next = IDLE;
        done_next  = 1'b1;
        fault_next = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wstrb_reg <= '0;
      size_reg  <= '0;
      uns_reg   <= 1'b0;
      we_reg    <= 1'b0;
      mem_r_reg <= '0;
      done_reg  <= 1'b0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      wstrb_reg <= wstrb_next;
      size_reg  <= size_next;
      uns_reg   <= uns_next;
      we_reg    <= we_next;
      mem_r_reg <= mem_r_next;
      done_reg  <= done_next;
      fault_reg <= fault_next;
    end
  end

  assign req_ready     = (state_reg == IDLE);
  assign busy          = (state_reg != IDLE);
  assign bus.bus_valid = (state_reg == REQ);
  assign bus.bus_we    = we_reg;
  assign bus.bus_addr  = {addr_reg[ISA_WIDTH-1:2], 2'b00};
  assign bus.bus_wdata = wdata_reg;
  assign bus.bus_wstrb = wstrb_reg;
  assign mem_r         = mem_r_reg;
  assign done          = done_reg;
  assign fault         = fault_reg;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed cases plus randomized accesses against a
// transaction-level model (access legality, end-to-end latency from bus wait
// states, lane arithmetic and a word-addressed memory).
module tb_lsu_ctrl;
  localparam int W      = 32;
  localparam int TO     = 4;
  localparam int BUDGET = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, mem_r_en, mem_w_en, mem_unsigned;
  logic [31:0] mem_addr, mem_w, mem_r;
  logic [1:0]  mem_size;
  logic        done, fault, busy;

  lsu_ctrl_if #(.ISA_WIDTH(W)) bus_if ();

  lsu_ctrl #(.ISA_WIDTH(W), .TIMEOUT(TO), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
    .mem_w(mem_w), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .bus(bus_if), .mem_r(mem_r), .done(done), .fault(fault), .busy(busy)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          txn_id   = 0;
  logic [31:0] ref_mem_r;
  logic [31:0] mem [logic [29:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [29:0] wa);
    if (!mem.exists(wa)) mem[wa] = $urandom;
    return mem[wa];
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [31:0] d);
    mem[a[31:2]] = d;
  endtask

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [31:0] a,
                                            input logic [1:0] size, input logic uns);
    logic [31:0] v;
    v = word;
    if (size == 2'd0) begin
      v = (word >> (8 * int'(a[1:0]))) & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFFFF00;
    end else if (size == 2'd1) begin
      v = (word >> (16 * int'(a[1]))) & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  // One access, entered at a negedge with the DUT idle or in its done cycle;
  // returns at the negedge of the done cycle so the next call is back-to-back.
  task automatic do_access(input logic r_en, input logic w_en, input logic [31:0] a,
                           input logic [31:0] w, input logic [1:0] size, input logic uns,
                           input int rd, input int vd, input logic err);
    logic        illegal, is_store, tmo, exp_fault, got_fault, hs, cap_we;
    logic [31:0] exp_wd, exp_mem_r, got_mem_r, pre_word, cap_addr, cap_wd, nw;
    logic [3:0]  exp_st, cap_st;
    int          h, e, exp_done, exp_nvalid, got_done, nvalid, first_valid;
    int          resp_idx, bad, unstable;
    string       op;

    illegal  = (size == 2'd3) || (size == 2'd1 && a[0]) ||
               (size == 2'd2 && a[1:0] != 2'b00) || (r_en && w_en);
    is_store = w_en && !r_en;
    case (size)
      2'd0:    begin exp_wd = {24'd0, w[7:0]}  * 32'h01010101; exp_st = 4'(1 << a[1:0]); end
      2'd1:    begin exp_wd = {16'd0, w[15:0]} * 32'h00010001; exp_st = 4'(3 << a[1:0]); end
      default: begin exp_wd = w; exp_st = 4'hF; end
    endcase
    if (!is_store) exp_st = 4'h0;
    pre_word = mem_rd(a[31:2]);

    // Timeline model: h = bus_valid cycles to handshake, e = edges to rvalid.
    h   = (rd < 0) ? 1000 : rd + 1;
    e   = h + vd + 1;
    tmo = 1'b0;
    if (illegal) begin
      exp_done = 2; exp_nvalid = 0; exp_fault = 1'b1;
    end else if (h > TO) begin
      exp_done = TO + 1; exp_nvalid = TO; exp_fault = 1'b1; tmo = 1'b1;
    end else if (e > TO) begin
      exp_done = TO + 1; exp_nvalid = h; exp_fault = 1'b1; tmo = 1'b1;
    end else begin
      exp_done = e + 1; exp_nvalid = h; exp_fault = err;
    end
    exp_mem_r = ref_mem_r;
    if (!illegal && !tmo && !err && !is_store) exp_mem_r = load_ext(pre_word, a, size, uns);

    req_valid = 1'b1; mem_r_en = r_en; mem_w_en = w_en; mem_addr = a;
    mem_w = w; mem_size = size; mem_unsigned = uns;
    check("req_ready", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    // Scramble request inputs: the access must use its latched copy.
    req_valid = 1'b0; mem_r_en = 1'($urandom); mem_w_en = 1'($urandom);
    mem_addr = $urandom; mem_w = $urandom; mem_size = 2'($urandom); mem_unsigned = 1'($urandom);

    got_done = 0; got_fault = 1'bx; got_mem_r = 'x; nvalid = 0; first_valid = 0;
    resp_idx = 0; bad = 0; unstable = 0; hs = 1'b0;
    cap_addr = '0; cap_wd = '0; cap_st = '0; cap_we = 1'b0;
    for (int k = 1; k <= BUDGET; k++) begin
      if (done) begin
        got_done = k; got_fault = fault; got_mem_r = mem_r;
        if (busy || !req_ready) bad++;
        break;
      end
      if (!busy || fault || mem_r !== ref_mem_r) bad++;
      if (bus_if.bus_valid) begin
        nvalid++;
        if (nvalid == 1) begin
          first_valid = k; cap_addr = bus_if.bus_addr; cap_wd = bus_if.bus_wdata;
          cap_st = bus_if.bus_wstrb; cap_we = bus_if.bus_we;
        end else if (bus_if.bus_addr !== cap_addr || bus_if.bus_wstrb !== cap_st ||
                     bus_if.bus_we !== cap_we || (is_store && bus_if.bus_wdata !== cap_wd)) begin
          unstable++;
        end
        bus_if.bus_ready  = (rd >= 0) && (nvalid - 1 == rd);
        hs                = hs | bus_if.bus_ready;
        bus_if.bus_rvalid = 1'($urandom);
        bus_if.bus_err    = 1'($urandom);
        bus_if.bus_rdata  = $urandom;
      end else if (hs) begin
        bus_if.bus_ready  = 1'b0;
        bus_if.bus_rvalid = (resp_idx == vd);
        bus_if.bus_err    = err;
        bus_if.bus_rdata  = mem_rd(cap_addr[31:2]);
        resp_idx++;
      end else begin
        bus_if.bus_ready = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_err = 1'b0;
      end
      @(negedge clk);
    end
    bus_if.bus_ready = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_err = 1'b0;

    check("done_cycle", got_done, exp_done);
    check("fault", {31'd0, got_fault}, {31'd0, exp_fault});
    check("mem_r", got_mem_r, exp_mem_r);
    check("valid_cycles", nvalid, exp_nvalid);
    check("busy_hold", bad, 0);
    if (exp_nvalid > 0) begin
      check("first_valid", first_valid, 1);
      check("bus_addr", cap_addr, {a[31:2], 2'b00});
      check("bus_we", {31'd0, cap_we}, {31'd0, is_store});
      check("bus_wstrb", {28'd0, cap_st}, {28'd0, exp_st});
      if (is_store) check("bus_wdata", cap_wd, exp_wd);
      check("bus_stable", unstable, 0);
    end

    ref_mem_r = exp_mem_r;
    if (is_store && !illegal && !tmo && !err) begin
      nw = pre_word;
      for (int b = 0; b < 4; b++) if (exp_st[b]) nw[8*b +: 8] = exp_wd[8*b +: 8];
      mem[a[31:2]] = nw;
    end
    op = (r_en && w_en) ? "rw" : (w_en ? "st" : "ld");
    $display("txn %0d: %s addr=%08h size=%0d uns=%0b rd=%0d vd=%0d err=%0b -> done@%0d fault=%0b mem_r=%08h",
             txn_id, op, a, size, uns, rd, vd, err, got_done, got_fault, got_mem_r);
    txn_id++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dseen;
    logic r_en, w_en, uns, err;
    logic [1:0]  size;
    logic [31:0] a, off;
    int rd, vd, opc;

    rst = 1'b1; req_valid = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0; mem_addr = '0;
    mem_w = '0; mem_size = '0; mem_unsigned = 1'b0;
    bus_if.bus_ready = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = '0; bus_if.bus_err = 1'b0;
    ref_mem_r = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done_fault", {done, fault}, 0);
    check("rst_bus_valid", bus_if.bus_valid, 0);
    check("rst_bus_we_strb", {bus_if.bus_we, bus_if.bus_wstrb}, 0);
    check("rst_bus_addr", bus_if.bus_addr, 0);
    check("rst_bus_wdata", bus_if.bus_wdata, 0);
    check("rst_mem_r", mem_r, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // lw zero-wait
    mem_wr(32'h80000104, 32'hDEADBEEF);
    do_access(1, 0, 32'h80000104, 32'h0, 2'd2, 0, 0, 0, 0);
    check("lw_value", mem_r, 32'hDEADBEEF);
    // lb signed / unsigned
    mem_wr(32'h80000100, 32'h80FF1234);
    do_access(1, 0, 32'h80000103, 32'h0, 2'd0, 0, 0, 0, 0);
    check("lb_sext", mem_r, 32'hFFFFFF80);
    do_access(1, 0, 32'h80000103, 32'h0, 2'd0, 1, 0, 0, 0);
    check("lbu_zext", mem_r, 32'h00000080);
    // sh: lanes checked by the model, mem_r must hold
    do_access(0, 1, 32'h80000002, 32'h0000ABCD, 2'd1, 0, 1, 1, 0);
    check("sh_mem_r_hold", mem_r, 32'h00000080);
    // misaligned lw, then a request accepted in its done cycle
    do_access(1, 0, 32'h80000001, 32'h0, 2'd2, 0, 0, 0, 0);
    do_access(1, 0, 32'h80000104, 32'h0, 2'd2, 0, 0, 0, 0);
    // bus_ready never asserted: timeout
    do_access(1, 0, 32'h80000108, 32'h0, 2'd2, 0, -1, 0, 0);

    // reset mid-REQ: bus_valid drops at once, no done afterwards
    req_valid = 1'b1; mem_r_en = 1'b1; mem_w_en = 1'b0; mem_addr = 32'h80000108; mem_size = 2'd2;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    check("rst_mid_valid_before", bus_if.bus_valid, 1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("rst_mid_valid_drop", bus_if.bus_valid, 0);
    check("rst_mid_busy", busy, 0);
    @(negedge clk); rst = 1'b0;
    ref_mem_r = '0;
    check("rst_mid_mem_r", mem_r, 0);
    dseen = 0;
    repeat (8) begin @(negedge clk); if (done) dseen++; end
    check("rst_mid_no_done", dseen, 0);

    // zero-wait sw then lw back-to-back, then a bus error on a load
    do_access(0, 1, 32'h00000010, 32'h13572468, 2'd2, 0, 0, 0, 0);
    do_access(1, 0, 32'h00000010, 32'h0, 2'd2, 0, 0, 0, 0);
    check("b2b_lw", mem_r, 32'h13572468);
    do_access(1, 0, 32'h80000104, 32'h0, 2'd2, 0, 0, 0, 1);
    check("err_mem_r_hold", mem_r, 32'h13572468);

    // req_valid with no enable is ignored
    req_valid = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0;
    @(negedge clk); req_valid = 1'b0;
    check("ignored_req", busy, 0);

    for (int i = 0; i < 250; i++) begin
      opc  = $urandom_range(0, 15);
      r_en = (opc < 8) || (opc == 15);
      w_en = (opc >= 8);
      size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 5) == 0)  off = 32'($urandom_range(0, 3));
      else if (size == 2'd0)          off = 32'($urandom_range(0, 3));
      else if (size == 2'd1)          off = 32'(2 * $urandom_range(0, 1));
      else                            off = 32'd0;
      a    = 32'h80000000 + 32'(4 * $urandom_range(0, 15)) + off;
      uns  = 1'($urandom);
      rd   = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 2);
      vd   = $urandom_range(0, 2);
      err  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) begin
        req_valid = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0;
        @(negedge clk); req_valid = 1'b0;
        check("ignored_req", busy, 0);
      end
      do_access(r_en, w_en, a, $urandom, size, uns, rd, vd, err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit that consumes the memory-request signals produced by the execute-stage memory decoder: mem_addr, mem_w, mem_r_en and mem_w_en.
- Runs a multi-cycle valid/ready transaction on the data bus and generates byte strobes for stores.
- Sign/zero-extends load data and returns it as mem_r to writeback.
- Exposes busy, done and fault so the core stalls while an access is outstanding.

Parameters:
- ISA_WIDTH, 32, data/address width (matches `ISA_WIDTH).
- TIMEOUT, 255, bus cycles allowed before an access faults. 0 disables the timeout.
- CNT_WIDTH, 8, width of the timeout counter. Must satisfy TIMEOUT < 2^CNT_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  execute stage presents an access this cycle.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- mem_r_en  in  1  load request.
- mem_w_en  in  1  store request.
- mem_addr  in  ISA_WIDTH  byte address.
- mem_w  in  ISA_WIDTH  store data, right-aligned.
- mem_size  in  2  0=byte, 1=half, 2=word, 3=illegal.
- mem_unsigned  in  1  1 = zero-extend loads (lbu/lhu).
- bus_valid  out  1  request on the bus.
- bus_ready  in  1  bus accepts the request.
- bus_we  out  1  1 = write.
- bus_addr  out  ISA_WIDTH  word-aligned address, {addr[31:2],2'b00}.
- bus_wdata  out  ISA_WIDTH  lane-replicated store data.
- bus_wstrb  out  4  byte strobes; 0 on reads.
- bus_rvalid  in  1  response/ack. Required for both reads and writes.
- bus_rdata  in  ISA_WIDTH  read data.
- bus_err  in  1  error, qualified by bus_rvalid.
- mem_r  out  ISA_WIDTH  extended load result. Holds until the next load completes.
- done  out  1  one-cycle pulse when an access finishes, with or without fault.
- fault  out  1  asserted with done on misalign, illegal size, r_en&&w_en, bus_err or timeout.
- busy  out  1  high when not in IDLE.

Behaviour:
- Reset (async):
  - State goes to IDLE and the counter clears.
  - All outputs go to 0 except req_ready=1: bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb, mem_r, done, fault, busy.
  - Asserting rst mid-transaction drops bus_valid immediately. The aborted access never signals done.
- Acceptance:
  - A request is accepted only if req_valid, req_ready and (mem_r_en|mem_w_en). A req_valid with neither enable is ignored.
  - On acceptance, addr, wdata, size, unsigned and we are latched. Later input changes have no effect.
- States: IDLE, REQ, RESP, FLT.
  - IDLE: an accepted request goes to REQ, or to FLT if it is illegal.
  - Illegal means any of: size=3; half with addr[0]=1; word with addr[1:0]!=0; r_en&&w_en.
  - REQ: bus_valid=1 and the bus outputs are stable. When bus_ready is sampled high, go to RESP. bus_rvalid is ignored in REQ.
  - RESP: bus_valid=0. When bus_rvalid is sampled high, go to IDLE. done pulses next cycle; fault = bus_err.
  - RESP load result: on a load with bus_err=0, mem_r is updated from bus_rdata. mem_r keeps its old value on a store or on bus_err.
  - FLT: go to IDLE after one cycle. done=fault=1 during the cycle after FLT. There is no bus activity.
- Latency: acceptance at T, bus_valid at T+1. With zero-wait bus_ready and bus_rvalid, done is at T+3.
- Back-to-back: req_ready=1 in the done cycle, so a new request may be accepted then.
- Store lanes:
  - byte: wdata={4{w[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - half: wdata={2{w[15:0]}}, wstrb=4'b0011<<addr[1:0].
  - word: wdata=w, wstrb=4'b1111.
- Load extract:
  - byte: rdata[8*addr[1:0]+:8]. half: rdata[16*addr[1]+:16].
  - Sign-extend unless mem_unsigned=1. Word is passed through.
- Timeout:
  - Counter clears on acceptance and increments each cycle in REQ or RESP.
  - When it reaches TIMEOUT (if TIMEOUT!=0) before completion: go to IDLE, bus_valid drops, done=fault=1 next cycle.
  - A completion and a timeout on the same edge: completion wins.
- done and fault are registered and are never high for more than one cycle per access.

Test Plan:
- lw addr=0x80000104, bus_ready and bus_rvalid zero-wait, rdata=0xDEADBEEF:
  - bus_valid at T+1, bus_addr=0x80000104, wstrb=0.
  - done at T+3, mem_r=0xDEADBEEF, fault=0.
- lb addr=0x80000103, rdata=0x80FF1234 -> mem_r=0xFFFFFF80. Same access with mem_unsigned=1 -> mem_r=0x00000080.
- sh addr=0x80000002, mem_w=0x0000ABCD -> bus_we=1, bus_wdata=0xABCDABCD, bus_wstrb=4'b1100. done after rvalid; mem_r unchanged.
- lw addr=0x80000001 -> no bus_valid ever; done=fault=1 at T+2. Next request accepted in the done cycle.
- bus_ready held low, TIMEOUT=4 -> bus_valid for 4 cycles, then done=fault=1. rst pulsed mid-REQ in a repeat run -> bus_valid=0 immediately, no done.
- Zero-wait back-to-back: sw to 0x10, then lw from 0x10 accepted in the sw done cycle; the bus model returns the stored word -> mem_r equals the stored word. Separately, bus_rvalid with bus_err=1 -> fault=1, mem_r keeps its old value.
